// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking network front end.
// The magnitude helper works on a 32-bit sign-extended value; callers truncate to their width.
package snn_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } enc_state_t;

   // The most negative input maps to 2^(w-1), which still fits in w unsigned bits.
   function automatic logic [31:0] signed_mag(input logic signed [31:0] value);
      return value[31] ? 32'(-value) : 32'(value);
   endfunction

   function automatic int acc_width(input int threshold);
      return $clog2(threshold) + 1;
   endfunction

endpackage

// File: rtl/spike_encoder_channel.sv
// One channel of the rate encoder: latched sign/magnitude plus an accumulate-and-subtract
// accumulator that emits at most one registered spike per step.
module spike_encoder_channel
   import snn_pkg::*;
#(
   parameter int VALUE_WIDTH = 8,
   parameter int THRESHOLD   = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   step,
   input  logic [VALUE_WIDTH-1:0] value,
   output logic                   pos_spike,
   output logic                   neg_spike
);

   localparam int ACC_WIDTH = acc_width(THRESHOLD);
   localparam logic [ACC_WIDTH-1:0] THRESH = ACC_WIDTH'(THRESHOLD);

   logic signed [31:0]     value_ext;
   logic                   neg_q, neg_d;
   logic [VALUE_WIDTH-1:0] mag_q, mag_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [ACC_WIDTH-1:0]   sum;
   logic                   pos_spike_q, pos_spike_d;
   logic                   neg_spike_q, neg_spike_d;

   assign value_ext = 32'(signed'(value));

   // acc < THRESHOLD and mag <= THRESHOLD, so sum < 2*THRESHOLD fits in ACC_WIDTH bits.
   always_comb begin
      neg_d       = neg_q;
      mag_d       = mag_q;
      acc_d       = acc_q;
      pos_spike_d = 1'b0;
      neg_spike_d = 1'b0;
      sum         = acc_q + ACC_WIDTH'(mag_q);
      if (load) begin
         neg_d = value[VALUE_WIDTH-1];
         mag_d = VALUE_WIDTH'(signed_mag(value_ext));
         acc_d = '0;
      end else if (step) begin
         if (sum >= THRESH) begin
            acc_d       = sum - THRESH;
            pos_spike_d = ~neg_q;
            neg_spike_d = neg_q;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_q       <= 1'b0;
         mag_q       <= '0;
         acc_q       <= '0;
         pos_spike_q <= 1'b0;
         neg_spike_q <= 1'b0;
      end else begin
         neg_q       <= neg_d;
         mag_q       <= mag_d;
         acc_q       <= acc_d;
         pos_spike_q <= pos_spike_d;
         neg_spike_q <= neg_spike_d;
      end
   end

   assign pos_spike = pos_spike_q;
   assign neg_spike = neg_spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes a vector of signed activations into per-channel spike trains over one window.
// Holds the IDLE/RUN FSM, step counter and handshake; channels do the accumulation.
module spike_rate_encoder
   import snn_pkg::*;
#(
   parameter int CHANNEL_COUNT = 4,
   parameter int VALUE_WIDTH   = 8,
   parameter int WINDOW_LEN    = 16,
   parameter int THRESHOLD     = 128
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [CHANNEL_COUNT*VALUE_WIDTH-1:0] in_values,
   input  logic                                 step_en,
   output logic [CHANNEL_COUNT-1:0]             positive_spike,
   output logic [CHANNEL_COUNT-1:0]             negative_spike,
   output logic                                 busy,
   output logic                                 window_done
);

   localparam int CNT_WIDTH = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WINDOW_LEN - 1);

   enc_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] step_cnt_q, step_cnt_d;
   logic                 window_done_q, window_done_d;
   logic                 accept;
   logic                 step;
   logic                 last_step;

   assign accept    = (state_q == IDLE) && in_valid;
   assign step      = (state_q == RUN) && step_en;
   assign last_step = step && (step_cnt_q == LAST_STEP);

   always_comb begin
      state_d       = state_q;
      step_cnt_d    = step_cnt_q;
      window_done_d = last_step;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = RUN;
               step_cnt_d = '0;
            end
         end
         RUN: begin
            if (last_step) begin
               state_d    = IDLE;
               step_cnt_d = '0;
            end else if (step) begin
               step_cnt_d = step_cnt_q + CNT_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         step_cnt_q    <= '0;
         window_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_cnt_q    <= step_cnt_d;
         window_done_q <= window_done_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q == RUN);
   assign window_done = window_done_q;

   for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_chan
      spike_encoder_channel #(
         .VALUE_WIDTH(VALUE_WIDTH),
         .THRESHOLD  (THRESHOLD)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .load     (accept),
         .step     (step),
         .value    (in_values[gi*VALUE_WIDTH +: VALUE_WIDTH]),
         .pos_spike(positive_spike[gi]),
         .neg_spike(negative_spike[gi])
      );
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: inputs driven and outputs sampled on the falling edge.
module tb_spike_rate_encoder;
   localparam int CH = 4;
   localparam int VW = 8;
   localparam int WL = 16;
   localparam int TH = 128;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [CH*VW-1:0] in_values;
   logic            step_en;
   logic [CH-1:0]   positive_spike;
   logic [CH-1:0]   negative_spike;
   logic            busy;
   logic            window_done;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   spike_rate_encoder #(
      .CHANNEL_COUNT(CH),
      .VALUE_WIDTH  (VW),
      .WINDOW_LEN   (WL),
      .THRESHOLD    (TH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_values     (in_values),
      .step_en       (step_en),
      .positive_spike(positive_spike),
      .negative_spike(negative_spike),
      .busy          (busy),
      .window_done   (window_done)
   );

   // Stimulus only: present a vector for one edge; returns at the first RUN-cycle falling edge.
   task automatic accept_vec(input logic [CH*VW-1:0] vals);
      in_values = vals;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      step_en   = 1'b0;
      in_values = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, busy, positive_spike, negative_spike, window_done} !== {1'b1, 1'b0, 4'b0, 4'b0, 1'b0})
         $display("FAIL reset rdy=%b busy=%b pos=%b neg=%b wd=%b exp rdy=1 busy=0 pos=0000 neg=0000 wd=0",
                  in_ready, busy, positive_spike, negative_spike, window_done);
      else passes++;
      reset = 1'b0;
      @(negedge clk);
      $display("txn reset done");
   endtask

   task automatic test_single();
      logic [CH-1:0] exp_pos;
      int cnt = 0;
      accept_vec(32'h0000_0040);
      checks++;
      if ({busy, in_ready} !== 2'b10)
         $display("FAIL single_accept busy=%b rdy=%b exp busy=1 rdy=0", busy, in_ready);
      else passes++;
      step_en = 1'b1;
      for (int s = 1; s <= WL; s++) begin
         @(negedge clk);
         exp_pos = '0;
         exp_pos[0] = (s % 2 == 0);
         cnt += int'(positive_spike[0]);
         checks++;
         if ({positive_spike, negative_spike, window_done} !== {exp_pos, 4'b0, (s == WL)})
            $display("FAIL single step%0d pos=%b neg=%b wd=%b exp pos=%b neg=0000 wd=%b",
                     s, positive_spike, negative_spike, window_done, exp_pos, (s == WL));
         else passes++;
      end
      step_en = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, in_ready, positive_spike, window_done, cnt} !== {1'b0, 1'b1, 4'b0, 1'b0, 8})
         $display("FAIL single_end busy=%b rdy=%b pos=%b wd=%b count=%0d exp busy=0 rdy=1 pos=0000 wd=0 count=8",
                  busy, in_ready, positive_spike, window_done, cnt);
      else passes++;
      $display("txn single v=64 spikes=%0d", cnt);
   endtask

   task automatic test_channels();
      logic [CH-1:0] exp_pos;
      accept_vec(32'h0001_807F);
      step_en = 1'b1;
      for (int s = 1; s <= WL; s++) begin
         @(negedge clk);
         exp_pos = '0;
         exp_pos[0] = (s >= 2);
         checks++;
         if ({positive_spike, negative_spike, window_done} !== {exp_pos, 4'b0010, (s == WL)})
            $display("FAIL channels step%0d pos=%b neg=%b wd=%b exp pos=%b neg=0010 wd=%b",
                     s, positive_spike, negative_spike, window_done, exp_pos, (s == WL));
         else passes++;
         checks++;
         if ((positive_spike & negative_spike) !== 4'b0)
            $display("FAIL channels_overlap step%0d both=%b exp 0000", s, positive_spike & negative_spike);
         else passes++;
      end
      step_en = 1'b0;
      @(negedge clk);
      $display("txn channels {127,-128,1,0} done");
   endtask

   task automatic test_step_toggle();
      logic [CH-1:0] exp_pos;
      logic          exp_wd;
      int s;
      int cnt = 0;
      accept_vec(32'h0000_0040);
      for (int c = 0; c < 2 * WL; c++) begin
         step_en = (c % 2 == 0);
         @(negedge clk);
         exp_pos = '0;
         exp_wd  = 1'b0;
         if (c % 2 == 0) begin
            s = c / 2 + 1;
            exp_pos[0] = (s % 2 == 0);
            exp_wd     = (s == WL);
         end
         cnt += int'(positive_spike[0]);
         checks++;
         if ({positive_spike, negative_spike, window_done} !== {exp_pos, 4'b0, exp_wd})
            $display("FAIL toggle cyc%0d pos=%b neg=%b wd=%b exp pos=%b neg=0000 wd=%b",
                     c, positive_spike, negative_spike, window_done, exp_pos, exp_wd);
         else passes++;
      end
      step_en = 1'b0;
      checks++;
      if (cnt !== 8) $display("FAIL toggle_count count=%0d exp 8", cnt);
      else passes++;
      @(negedge clk);
      $display("txn toggle v=64 spikes=%0d", cnt);
   endtask

   task automatic test_back_to_back();
      logic [CH-1:0] exp_pos;
      logic [CH-1:0] exp_neg;
      in_values = 32'h0000_0040;
      in_valid  = 1'b1;
      @(negedge clk);
      step_en = 1'b1;
      for (int s = 1; s <= WL; s++) begin
         @(negedge clk);
         exp_pos = '0;
         exp_pos[0] = (s % 2 == 0);
         checks++;
         if ({positive_spike, window_done, in_ready} !== {exp_pos, (s == WL), (s == WL)})
            $display("FAIL b2b_first step%0d pos=%b wd=%b rdy=%b exp pos=%b wd=%b rdy=%b",
                     s, positive_spike, window_done, in_ready, exp_pos, (s == WL), (s == WL));
         else passes++;
      end
      in_values = 32'h0000_00E0;
      @(negedge clk);
      checks++;
      if ({busy, positive_spike, negative_spike, window_done} !== {1'b1, 4'b0, 4'b0, 1'b0})
         $display("FAIL b2b_accept busy=%b pos=%b neg=%b wd=%b exp busy=1 pos=0000 neg=0000 wd=0",
                  busy, positive_spike, negative_spike, window_done);
      else passes++;
      in_valid = 1'b0;
      for (int s = 1; s <= WL; s++) begin
         @(negedge clk);
         exp_neg = '0;
         exp_neg[0] = (s % 4 == 0);
         checks++;
         if ({positive_spike, negative_spike, window_done} !== {4'b0, exp_neg, (s == WL)})
            $display("FAIL b2b_second step%0d pos=%b neg=%b wd=%b exp pos=0000 neg=%b wd=%b",
                     s, positive_spike, negative_spike, window_done, exp_neg, (s == WL));
         else passes++;
      end
      step_en = 1'b0;
      @(negedge clk);
      $display("txn back_to_back 64 then -32 done");
   endtask

   task automatic test_input_stability();
      logic [CH-1:0] exp_pos;
      accept_vec(32'h0000_0040);
      step_en = 1'b1;
      for (int s = 1; s <= WL; s++) begin
         @(negedge clk);
         exp_pos = '0;
         exp_pos[0] = (s % 2 == 0);
         checks++;
         if ({positive_spike, negative_spike, in_ready} !== {exp_pos, 4'b0, (s == WL)})
            $display("FAIL stable step%0d pos=%b neg=%b rdy=%b exp pos=%b neg=0000 rdy=%b",
                     s, positive_spike, negative_spike, in_ready, exp_pos, (s == WL));
         else passes++;
         if (s == 3) begin
            in_values = 32'h8080_8080;
            in_valid  = 1'b1;
         end
      end
      in_valid = 1'b0;
      step_en  = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, in_ready} !== 2'b01)
         $display("FAIL stable_end busy=%b rdy=%b exp busy=0 rdy=1", busy, in_ready);
      else passes++;
      $display("txn input_stability done");
   endtask

   task automatic test_reset_mid_window();
      logic [CH-1:0] exp_pos;
      int cnt = 0;
      accept_vec(32'h0000_007F);
      step_en = 1'b1;
      for (int s = 1; s <= 7; s++) @(negedge clk);
      checks++;
      if ({busy, positive_spike} !== {1'b1, 4'b0001})
         $display("FAIL midreset_pre busy=%b pos=%b exp busy=1 pos=0001", busy, positive_spike);
      else passes++;
      reset = 1'b1;
      #1;
      checks++;
      if ({in_ready, busy, positive_spike, negative_spike, window_done} !== {1'b1, 1'b0, 4'b0, 4'b0, 1'b0})
         $display("FAIL midreset rdy=%b busy=%b pos=%b neg=%b wd=%b exp rdy=1 busy=0 pos=0000 neg=0000 wd=0",
                  in_ready, busy, positive_spike, negative_spike, window_done);
      else passes++;
      step_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      accept_vec(32'h0000_0040);
      step_en = 1'b1;
      for (int s = 1; s <= WL; s++) begin
         @(negedge clk);
         exp_pos = '0;
         exp_pos[0] = (s % 2 == 0);
         cnt += int'(positive_spike[0]);
         checks++;
         if ({positive_spike, window_done} !== {exp_pos, (s == WL)})
            $display("FAIL postreset step%0d pos=%b wd=%b exp pos=%b wd=%b",
                     s, positive_spike, window_done, exp_pos, (s == WL));
         else passes++;
      end
      step_en = 1'b0;
      checks++;
      if (cnt !== 8) $display("FAIL postreset_count count=%0d exp 8", cnt);
      else passes++;
      @(negedge clk);
      $display("txn reset_mid_window then v=64 spikes=%0d", cnt);
   endtask

   initial begin
      test_reset();
      test_single();
      test_channels();
      test_step_toggle();
      test_back_to_back();
      test_input_stability();
      test_reset_mid_window();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
